// File: rtl/barrier_ctrl.sv
// barrier_ctrl: game-side controller for a single barrier sprite.
// Spawns barrier passes after a pseudo-random idle gap, judges each pass as
// a collision or a clear, and maintains lives, score and game-over status.
// The v_sync rising edge is the frame tick; everything runs on i_clk.
module barrier_ctrl #(
    parameter int         LIVES_INIT    = 3,
    parameter int         TRAVEL_FRAMES = 36,
    parameter int         MIN_GAP       = 2,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_v_sync,
    input  logic       i_enable,
    input  logic       i_barrier_hit,
    input  logic       i_player_hit,
    input  logic       i_in_position,
    output logic       o_active,
    output logic       o_collision,
    output logic       o_cleared,
    output logic [1:0] o_lives,
    output logic [7:0] o_score,
    output logic       o_game_over,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_RUN   = 3'd2,
        S_HIT   = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [7:0] MIN_GAP_W = 8'(MIN_GAP);
    localparam logic [7:0] TRAVEL_W  = 8'(TRAVEL_FRAMES);
    localparam logic [1:0] LIVES_W   = 2'(LIVES_INIT);
    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    state_t     state_reg, state_next;
    logic       vs_d_reg;
    logic [7:0] lfsr_reg, lfsr_next;
    logic [7:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic       hit_latch_reg, hit_latch_next;
    logic [1:0] lives_reg, lives_next;
    logic [7:0] score_reg, score_next;
    logic       active_reg, collision_reg, cleared_reg, game_over_reg;

    logic       f_tick;
    logic       hit_now;
    logic [7:0] lfsr_step;
    logic [1:0] lives_dec;

    assign f_tick    = i_v_sync & ~vs_d_reg;
    assign hit_now   = i_in_position & i_barrier_hit & i_player_hit;
    assign lfsr_step = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 8'h00);
    assign lives_dec = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;

    // Next-state and datapath decisions for the pass sequencer
    always_comb begin
        state_next     = state_reg;
        gap_cnt_next   = gap_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        hit_latch_next = hit_latch_reg;
        lives_next     = lives_reg;
        score_next     = score_reg;
        // The LFSR freezes once the game is over so the spawn pattern is
        // only a function of frames actually played.
        lfsr_next      = (f_tick && state_reg != S_OVER) ? lfsr_step : lfsr_reg;

        case (state_reg)
            S_IDLE: begin
                if (i_enable && lives_reg != 2'd0) begin
                    state_next   = S_GAP;
                    gap_cnt_next = MIN_GAP_W + {4'd0, lfsr_reg[3:0]};
                end
            end
            S_GAP: begin
                if (!i_enable) begin
                    state_next     = S_IDLE;
                    hit_latch_next = 1'b0;
                end else if (f_tick) begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_next     = S_RUN;
                        frame_cnt_next = 8'd0;
                        hit_latch_next = 1'b0;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - 8'd1;
                    end
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    state_next     = S_IDLE;
                    hit_latch_next = 1'b0;
                end else begin
                    if (hit_now) begin
                        hit_latch_next = 1'b1;
                    end
                    if (f_tick) begin
                        // A hit seen in the final frame beats the timeout
                        if (hit_latch_reg || hit_now) begin
                            state_next = S_HIT;
                        end else if (frame_cnt_reg + 8'd1 == TRAVEL_W) begin
                            state_next = S_CLEAR;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 8'd1;
                        end
                    end
                end
            end
            S_HIT: begin
                lives_next = lives_dec;
                state_next = (lives_dec == 2'd0) ? S_OVER : S_IDLE;
            end
            S_CLEAR: begin
                score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                state_next = S_IDLE;
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= S_IDLE;
            vs_d_reg      <= 1'b0;
            lfsr_reg      <= LFSR_SEED;
            gap_cnt_reg   <= 8'd0;
            frame_cnt_reg <= 8'd0;
            hit_latch_reg <= 1'b0;
            lives_reg     <= LIVES_W;
            score_reg     <= 8'd0;
            active_reg    <= 1'b0;
            collision_reg <= 1'b0;
            cleared_reg   <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            vs_d_reg      <= i_v_sync;
            lfsr_reg      <= lfsr_next;
            gap_cnt_reg   <= gap_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            hit_latch_reg <= hit_latch_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            active_reg    <= (state_next == S_RUN);
            collision_reg <= (state_next == S_HIT);
            cleared_reg   <= (state_next == S_CLEAR);
            game_over_reg <= (state_next == S_OVER);
        end
    end

    assign o_active    = active_reg;
    assign o_collision = collision_reg;
    assign o_cleared   = cleared_reg;
    assign o_lives     = lives_reg;
    assign o_score     = score_reg;
    assign o_game_over = game_over_reg;
    assign o_state     = state_reg;

endmodule

// File: tb/tb_barrier_ctrl.sv
// tb_barrier_ctrl: directed bench for barrier_ctrl with a pass-result
// scoreboard. A second instance with one-frame travel and no minimum gap
// drives the score into saturation quickly.
module tb_barrier_ctrl;

    localparam int         TRAVEL = 36;
    localparam int         GAP    = 2;
    localparam logic [7:0] SEED   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, v_sync, enable, bhit, phit, inpos;
    logic       active, collision, cleared, game_over;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;

    logic       v2, en2, zero2;
    logic       active2, coll2, clr2, go2;
    logic [1:0] lives2;
    logic [7:0] score2;
    logic [2:0] state2;

    always #5 clk = ~clk;

    barrier_ctrl #(.LIVES_INIT(3), .TRAVEL_FRAMES(TRAVEL), .MIN_GAP(GAP), .LFSR_SEED(SEED)) dut (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_enable(enable),
        .i_barrier_hit(bhit), .i_player_hit(phit), .i_in_position(inpos),
        .o_active(active), .o_collision(collision), .o_cleared(cleared),
        .o_lives(lives), .o_score(score), .o_game_over(game_over), .o_state(state)
    );

    barrier_ctrl #(.LIVES_INIT(3), .TRAVEL_FRAMES(1), .MIN_GAP(0), .LFSR_SEED(SEED)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v2), .i_enable(en2),
        .i_barrier_hit(zero2), .i_player_hit(zero2), .i_in_position(zero2),
        .o_active(active2), .o_collision(coll2), .o_cleared(clr2),
        .o_lives(lives2), .o_score(score2), .o_game_over(go2), .o_state(state2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         coll;
        logic [1:0] lives;
        logic [7:0] score;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_lfsr;
    logic [1:0] m_lives;
    logic [7:0] m_score;
    bit         m_over;
    int         pass_no = 0;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One frame: tick on the first cycle, optional one-cycle hit mid-frame.
    task automatic frame(input bit hit_tick, input bit hit_mid, input bit decoy);
        @(negedge clk);
        v_sync = 1'b1;
        if (hit_tick) begin bhit = 1'b1; phit = 1'b1; inpos = 1'b1; end
        @(negedge clk);
        bhit = 1'b0; phit = 1'b0; inpos = 1'b0;
        if (!m_over) m_lfsr = lfsr_adv(m_lfsr);
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
        if (hit_mid) begin bhit = 1'b1; phit = 1'b1; inpos = 1'b1; end
        else if (decoy) begin bhit = 1'b1; phit = 1'b1; inpos = 1'b0; end
        @(negedge clk);
        if (!decoy) begin bhit = 1'b0; phit = 1'b0; inpos = 1'b0; end
        @(negedge clk);
        bhit = 1'b0; phit = 1'b0; inpos = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v_sync = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_pulses", 32'(collision | cleared), 32'd0);
        rst = 1'b0;
        m_lfsr = SEED; m_lives = 2'd3; m_score = 8'd0; m_over = 1'b0;
    endtask

    // mode: 0 clean clear, 1 hit mid-frame h, 2 hit on final tick,
    //       3 hits without in_position, 4 hit mid-frame h then enable drop
    task automatic run_pass(input int mode, input int h);
        int g;
        bit end_hit, end_clr;
        g = GAP + int'(m_lfsr[3:0]);
        pass_no++;
        $display("pass %0d mode=%0d h=%0d gap=%0d lives=%0d score=%0d",
                 pass_no, mode, h, g, m_lives, m_score);
        for (int i = 0; i < g; i++) frame(1'b0, 1'b0, 1'b0);
        check("gap_state", 32'(state), 32'd1);
        check("gap_active", 32'(active), 32'd0);
        frame(1'b0, 1'b0, 1'b0);
        check("run_state", 32'(state), 32'd2);
        check("run_active", 32'(active), 32'd1);
        for (int k = 1; k <= TRAVEL; k++) begin
            end_hit = (mode == 1 && k == h + 1) || (mode == 2 && k == TRAVEL);
            end_clr = !end_hit && (k == TRAVEL);
            if (end_hit) begin
                if (m_lives != 2'd0) m_lives = m_lives - 2'd1;
                sb.push_back('{coll: 1'b1, lives: m_lives, score: m_score});
            end else if (end_clr) begin
                if (m_score != 8'hFF) m_score = m_score + 8'd1;
                sb.push_back('{coll: 1'b0, lives: m_lives, score: m_score});
            end
            frame(mode == 2 && k == TRAVEL, (mode == 1 || mode == 4) && k == h, mode == 3);
            if (end_hit || end_clr) begin
                check("end_active", 32'(active), 32'd0);
                if (end_hit && m_lives == 2'd0) m_over = 1'b1;
                break;
            end
            check("run_active_k", 32'(active), 32'd1);
            if (mode == 4 && k == h) begin
                enable = 1'b0;
                @(negedge clk);
                check("abort_state", 32'(state), 32'd0);
                check("abort_active", 32'(active), 32'd0);
                repeat (3) @(negedge clk);
                check("abort_lives", 32'(lives), 32'(m_lives));
                check("abort_score", 32'(score), 32'(m_score));
                enable = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard consumer: every result pulse must match the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (collision === 1'b1 || cleared === 1'b1)) begin
                check("pulse_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_collision", 32'(collision), 32'(e.coll));
                    check("pulse_cleared", 32'(cleared), 32'(!e.coll));
                    @(negedge clk);
                    check("pulse_width", 32'(collision | cleared), 32'd0);
                    check("lives_after", 32'(lives), 32'(e.lives));
                    check("score_after", 32'(score), 32'(e.score));
                    $display("result %s lives=%0d score=%0d",
                             e.coll ? "collision" : "cleared", lives, score);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int n;
        int cyc;
        bit pend;
        rst = 1'b1; v_sync = 1'b0; enable = 1'b0;
        bhit = 1'b0; phit = 1'b0; inpos = 1'b0;
        v2 = 1'b0; en2 = 1'b0; zero2 = 1'b0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        check("idle_to_gap", 32'(state), 32'd1);

        run_pass(0, 0);
        run_pass(3, 0);
        run_pass(1, 28);
        run_pass(2, 0);
        run_pass(4, 5);
        run_pass(0, 0);

        do_reset();
        run_pass(1, 1);
        run_pass(1, 17);
        run_pass(1, 35);
        check("over_game_over", 32'(game_over), 32'd1);
        check("over_state", 32'(state), 32'd5);
        check("over_lives", 32'(lives), 32'd0);
        repeat (100) frame(1'b0, 1'b0, 1'b0);
        check("over_hold_state", 32'(state), 32'd5);
        check("over_hold_active", 32'(active), 32'd0);
        check("over_hold_game_over", 32'(game_over), 32'd1);
        $display("over held 100 frames state=%0d active=%0d", state, active);
        do_reset();
        enable = 1'b0;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Score saturation on the short-travel instance
        en2 = 1'b1; n = 0; cyc = 0; pend = 1'b0;
        while (n < 258 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            v2 = ((cyc % 4) < 2);
            if (pend) begin
                check("sat_score", 32'(score2), 32'((n > 255) ? 255 : n));
                if (n >= 253) $display("sat clear %0d score=%0d", n, score2);
                pend = 1'b0;
            end
            if (clr2 === 1'b1) begin
                n++;
                pend = 1'b1;
            end
        end
        check("sat_clear_count", 32'(n), 32'd258);
        @(negedge clk);
        check("sat_final_score", 32'(score2), 32'd255);
        check("sat_lives", 32'(lives2), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
